// File: rtl/inst_queue_reg_pkg.sv
// Shared definitions for the instruction queue / instruction register slice.
// Holds the default widths, the MIPS field bit positions, the NOP encoding
// and a helper that splits a 32-bit instruction word into its fields.
package inst_queue_reg_pkg;

  localparam int DEF_INST_W = 32;
  localparam int DEF_PC_W   = 32;
  localparam int DEF_DEPTH  = 4;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int JA_HI  = 25;
  localparam int JA_LO  = 0;

  // All-zero word decodes as sll $0,$0,0.
  localparam logic [31:0] INST_NOP = 32'h0;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jaddr;
  } fields_t;

  function automatic fields_t decode_fields(input logic [31:0] inst);
    fields_t f;
    f.opcode = inst[OP_HI:OP_LO];
    f.rs     = inst[RS_HI:RS_LO];
    f.rt     = inst[RT_HI:RT_LO];
    f.rd     = inst[RD_HI:RD_LO];
    f.shamt  = inst[SH_HI:SH_LO];
    f.funct  = inst[FN_HI:FN_LO];
    f.imm16  = inst[IMM_HI:IMM_LO];
    f.jaddr  = inst[JA_HI:JA_LO];
    return f;
  endfunction

endpackage

// File: rtl/inst_queue_reg_if.sv
// Fetch-side valid/ready bus carrying an instruction word and its PC.
//   master : fetch unit (drives in_valid, in_inst, in_pc; sees in_ready)
//   slave  : instruction queue (sees the offer; drives in_ready)
interface inst_queue_reg_if
  import inst_queue_reg_pkg::*;
#(
  parameter int INST_W = DEF_INST_W,
  parameter int PC_W   = DEF_PC_W
);
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic [PC_W-1:0]   in_pc;

  modport master (output in_valid, output in_inst, output in_pc, input in_ready);
  modport slave  (input in_valid, input in_inst, input in_pc, output in_ready);
endinterface

// File: rtl/inst_queue_reg_fifo.sv
// inst_fifo: DEPTH x W synchronous FIFO with a combinational head read.
// Ports:
//   clk, reset        clock, asynchronous active-high reset (pointers/count)
//   push, wdata       write request and data (ignored when full or flushing)
//   pop               advance head (ignored when empty or flushing)
//   flush             clear pointers and count
//   rdata             current head entry
//   count/full/empty  occupancy status
module inst_fifo
  import inst_queue_reg_pkg::*;
#(
  parameter int W     = DEF_INST_W + DEF_PC_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only occupancy state does.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointer increment wraps on its own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_queue_reg.sv
// inst_queue_reg: prefetch queue in front of the instruction register.
// Fetched {inst, pc} pairs are buffered in inst_fifo; ir_write moves the head
// into the IR, whose decoded MIPS fields stay stable until the next load.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   fetch           valid/ready fetch bus (in_valid, in_ready, in_inst, in_pc)
//   ir_write        load head entry into the IR (bubble if queue empty)
//   flush           drop queue and invalidate IR; beats push and load
//   ir_valid/ir_inst/ir_pc  IR state
//   opcode..jaddr   field slices of ir_inst
//   count/empty/full        queue occupancy
module inst_queue_reg
  import inst_queue_reg_pkg::*;
#(
  parameter int INST_W = DEF_INST_W,
  parameter int PC_W   = DEF_PC_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  inst_queue_reg_if.slave              fetch,
  input  logic                         ir_write,
  input  logic                         flush,
  output logic                         ir_valid,
  output logic [INST_W-1:0]            ir_inst,
  output logic [PC_W-1:0]              ir_pc,
  output logic [5:0]                   opcode,
  output logic [4:0]                   rs,
  output logic [4:0]                   rt,
  output logic [4:0]                   rd,
  output logic [4:0]                   shamt,
  output logic [5:0]                   funct,
  output logic [15:0]                  imm16,
  output logic [25:0]                  jaddr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  logic [INST_W+PC_W-1:0] head;
  logic                   load;
  fields_t                fields;

  // Ready comes from occupancy alone, so ir_write never reaches in_ready.
  assign fetch.in_ready = !full;
  assign load           = ir_write && !empty && !flush;

  inst_fifo #(
    .W     (INST_W + PC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fetch.in_valid),
    .pop   (ir_write),
    .flush (flush),
    .wdata ({fetch.in_inst, fetch.in_pc}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // IR stage: flush clears to NOP; ir_write on an empty queue is a bubble
  // that keeps the old contents but marks them stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_valid <= 1'b0;
      ir_inst  <= INST_W'(INST_NOP);
      ir_pc    <= '0;
    end else if (flush) begin
      ir_valid <= 1'b0;
      ir_inst  <= INST_W'(INST_NOP);
      ir_pc    <= '0;
    end else if (load) begin
      ir_valid <= 1'b1;
      ir_inst  <= head[INST_W+PC_W-1:PC_W];
      ir_pc    <= head[PC_W-1:0];
    end else if (ir_write) begin
      ir_valid <= 1'b0;
    end
  end

  assign fields = decode_fields(ir_inst);
  assign opcode = fields.opcode;
  assign rs     = fields.rs;
  assign rt     = fields.rt;
  assign rd     = fields.rd;
  assign shamt  = fields.shamt;
  assign funct  = fields.funct;
  assign imm16  = fields.imm16;
  assign jaddr  = fields.jaddr;

endmodule

// File: tb/tb_inst_queue_reg.sv
module tb_inst_queue_reg;
  import inst_queue_reg_pkg::*;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          ir_write;
  logic          flush;
  logic          ir_valid;
  logic [31:0]   ir_inst;
  logic [31:0]   ir_pc;
  logic [5:0]    opcode;
  logic [4:0]    rs, rt, rd, shamt;
  logic [5:0]    funct;
  logic [15:0]   imm16;
  logic [25:0]   jaddr;
  logic [CW-1:0] count;
  logic          empty, full;

  inst_queue_reg_if #(.INST_W(INST_W), .PC_W(PC_W)) bus ();

  inst_queue_reg #(.INST_W(INST_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .fetch    (bus),
    .ir_write (ir_write),
    .flush    (flush),
    .ir_valid (ir_valid),
    .ir_inst  (ir_inst),
    .ir_pc    (ir_pc),
    .opcode   (opcode),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .funct    (funct),
    .imm16    (imm16),
    .jaddr    (jaddr),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain queue of pending entries plus the IR contents.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;
  ent_t        q[$];
  logic        m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, "_count"},    64'(count),         64'(n));
    check({tag, "_empty"},    64'(empty),         64'(n == 0));
    check({tag, "_full"},     64'(full),          64'(n == DEPTH));
    check({tag, "_in_ready"}, 64'(bus.in_ready),  64'(n < DEPTH));
    check({tag, "_ir_valid"}, 64'(ir_valid),      64'(m_valid));
    check({tag, "_ir_inst"},  64'(ir_inst),       64'(m_inst));
    check({tag, "_ir_pc"},    64'(ir_pc),         64'(m_pc));
    check({tag, "_opcode"},   64'(opcode),        64'((m_inst >> 26) & 32'h3f));
    check({tag, "_rs"},       64'(rs),            64'((m_inst >> 21) & 32'h1f));
    check({tag, "_rt"},       64'(rt),            64'((m_inst >> 16) & 32'h1f));
    check({tag, "_rd"},       64'(rd),            64'((m_inst >> 11) & 32'h1f));
    check({tag, "_shamt"},    64'(shamt),         64'((m_inst >> 6) & 32'h1f));
    check({tag, "_funct"},    64'(funct),         64'(m_inst & 32'h3f));
    check({tag, "_imm16"},    64'(imm16),         64'(m_inst & 32'hffff));
    check({tag, "_jaddr"},    64'(jaddr),         64'(m_inst & 32'h03ff_ffff));
  endtask

  task automatic model_clear();
    q.delete();
    m_valid = 1'b0;
    m_inst  = 32'h0;
    m_pc    = 32'h0;
  endtask

  // One clock edge of the reference behaviour, using pre-edge occupancy.
  task automatic model_edge(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                            input logic irw, input logic fl);
    bit   can_push;
    ent_t e;
    if (fl) begin
      q.delete();
      m_valid = 1'b0;
      m_inst  = 32'h0;
      m_pc    = 32'h0;
    end else begin
      can_push = v && (q.size() < DEPTH);
      if (irw) begin
        if (q.size() > 0) begin
          e       = q.pop_front();
          m_inst  = e.inst;
          m_pc    = e.pc;
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (can_push) begin
        e.inst = inst;
        e.pc   = pc;
        q.push_back(e);
      end
    end
  endtask

  // Called at a falling edge: drive, step through one rising edge, check.
  task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic irw, input logic fl, input string tag);
    bus.in_valid = v;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
    ir_write     = irw;
    flush        = fl;
    model_edge(v, inst, pc, irw, fl);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    ir_write     = 1'b0;
    flush        = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] w;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_inst  = 32'h0;
    bus.in_pc    = 32'h0;
    ir_write     = 1'b0;
    flush        = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_all("reset");

    // Single push then load: lw $2,4($1).
    cycle(1'b1, 32'h8C220004, 32'h00400000, 1'b0, 1'b0, "t1_push");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t1_load");
    check("t1_opcode_const", 64'(opcode),   64'h23);
    check("t1_rs_const",     64'(rs),       64'd1);
    check("t1_rt_const",     64'(rt),       64'd2);
    check("t1_imm_const",    64'(imm16),    64'h0004);
    check("t1_pc_const",     64'(ir_pc),    64'h00400000);
    check("t1_valid_const",  64'(ir_valid), 64'd1);
    check("t1_count_const",  64'(count),    64'd0);

    // Fill to full, offer a fifth word, drain in order, then refill across wrap.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h1000_0000 + 32'(i), 32'h0040_0100 + 32'(4 * i), 1'b0, 1'b0, "t2_fill");
    check("t2_full_const",  64'(full),         64'd1);
    check("t2_ready_const", 64'(bus.in_ready), 64'd0);
    cycle(1'b1, 32'hBAD0_0005, 32'h0040_0200, 1'b0, 1'b0, "t2_over");
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t2_drain");
      check("t2_order", 64'(ir_inst), 64'(32'h1000_0000 + 32'(i)));
    end
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h2000_0000 + 32'(i), 32'h0040_0300 + 32'(4 * i), 1'b0, 1'b0, "t2_wrapfill");
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t2_wrapdrain");

    // Push and load together with two queued entries.
    cycle(1'b1, 32'h3000_0001, 32'h0040_0400, 1'b0, 1'b0, "t3_a");
    cycle(1'b1, 32'h3000_0002, 32'h0040_0404, 1'b0, 1'b0, "t3_b");
    cycle(1'b1, 32'h3000_0003, 32'h0040_0408, 1'b1, 1'b0, "t3_both");
    check("t3_count_const", 64'(count),   64'd2);
    check("t3_older_const", 64'(ir_inst), 64'h3000_0001);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t3_d1");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t3_d2");

    // Load while empty keeps contents but drops valid.
    cycle(1'b1, 32'h012A4020, 32'h0040_0500, 1'b0, 1'b0, "t4_push");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t4_load");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t4_bubble");
    check("t4_hold_const",  64'(ir_inst),  64'h012A4020);
    check("t4_valid_const", 64'(ir_valid), 64'd0);
    cycle(1'b1, 32'h0043_1020, 32'h0040_0504, 1'b0, 1'b0, "t4_push2");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t4_load2");

    // Flush beats a simultaneous push and load.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h4000_0000 + 32'(i), 32'h0040_0600 + 32'(4 * i), 1'b0, 1'b0, "t5_fill");
    cycle(1'b1, 32'hDEADBEEF, 32'h0040_0700, 1'b1, 1'b1, "t5_flush");
    check("t5_inst_const",  64'(ir_inst),  64'h0);
    check("t5_count_const", 64'(count),    64'd0);
    cycle(1'b1, 32'h5000_0000, 32'h0040_0800, 1'b0, 1'b0, "t5_after");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t5_load");
    check("t5_notdropped", 64'(ir_inst), 64'h5000_0000);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t5_bubble");

    // Asynchronous reset between clock edges with three entries queued.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h6000_0000 + 32'(i), 32'h0040_0900 + 32'(4 * i), 1'b0, 1'b0, "t6_fill");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t6_load");
    #2 reset = 1'b1;
    #1;
    model_clear();
    check_all("t6_async");
    @(negedge clk);
    reset = 1'b0;
    check_all("t6_release");

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      w = $urandom();
      cycle($urandom_range(0, 99) < 60, w, $urandom(),
            $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 4, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
